// File: rtl/regbank_sb.sv
`default_nettype none
// ============================================================================
// Module      : regbank_sb
// Description : DEPTH x WIDTH register bank with a load scoreboard.
//               One primary write port (ALU / REG / IMM / zero source), one
//               independent memory write-back port that completes loads, a
//               per-register busy bit for loads in flight and a per-register
//               kill bit that discards a load return overtaken by a younger
//               primary write. Two combinational read ports.
//
// Optional    : REGBANK_SB_BYPASS_EN -- when defined, the read ports forward
//               same-cycle primary write data or accepted MEM write-back data.
//
// Ports
//   i_clk                clock, rising edge
//   i_reset              synchronous active-high reset
//   i_e                  global enable for primary write and load issue
//   i_we / i_wsel        primary write request / destination
//   i_ms                 source select: 0 ALU, 1 REG, 2 IMM, 3 zero
//   i_alu/i_reg/i_imm    primary write sources
//   i_ld_issue/i_ld_dst  load issue / destination (marks busy)
//   i_mem_valid/i_mem_dst/i_mem  load write-back
//   i_ra_sel/i_rb_sel    read indices
//   o_ra/o_rb            read data
//   o_ra_busy/o_rb_busy  busy bit of the selected register
//   o_busy               full scoreboard vector
//
// Revision    : 1.0  initial release
// ============================================================================
module regbank_sb #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 8,
    parameter int                 AW        = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_e,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wsel,
    input  logic [1:0]       i_ms,
    input  logic [WIDTH-1:0] i_alu,
    input  logic [WIDTH-1:0] i_reg,
    input  logic [WIDTH-1:0] i_imm,
    input  logic             i_ld_issue,
    input  logic [AW-1:0]    i_ld_dst,
    input  logic             i_mem_valid,
    input  logic [AW-1:0]    i_mem_dst,
    input  logic [WIDTH-1:0] i_mem,
    input  logic [AW-1:0]    i_ra_sel,
    input  logic [AW-1:0]    i_rb_sel,
    output logic [WIDTH-1:0] o_ra,
    output logic [WIDTH-1:0] o_rb,
    output logic             o_ra_busy,
    output logic             o_rb_busy,
    output logic [DEPTH-1:0] o_busy
);

    localparam logic [1:0] c_MS_ALU = 2'd0;
    localparam logic [1:0] c_MS_REG = 2'd1;
    localparam logic [1:0] c_MS_IMM = 2'd2;

    logic             w_pw_fire;
    logic             w_ld_fire;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_busy;

    // Enable gates the issue-side events only; load returns are never
    // dropped because memory has no way to retry them.
    assign w_pw_fire = i_we & i_e;
    assign w_ld_fire = i_ld_issue & i_e;

    always_comb begin
        w_src = '0;
        case (i_ms)
            c_MS_ALU: w_src = i_alu;
            c_MS_REG: w_src = i_reg;
            c_MS_IMM: w_src = i_imm;
            default:  w_src = '0;
        endcase
    end

`ifdef REGBANK_SB_BYPASS_EN
    logic [DEPTH-1:0] w_kill;
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [WIDTH-1:0] r_data;
            logic             r_busy;
            logic             r_kill;
            logic             w_mem_hit;
            logic             w_pw_hit;
            logic             w_ld_hit;
            logic [WIDTH-1:0] w_data_nxt;
            logic             w_busy_nxt;
            logic             w_kill_nxt;

            assign w_mem_hit = i_mem_valid && (i_mem_dst == AW'(gi));
            assign w_pw_hit  = w_pw_fire   && (i_wsel    == AW'(gi));
            assign w_ld_hit  = w_ld_fire   && (i_ld_dst  == AW'(gi));

            // Same-index events are applied oldest first (MEM return,
            // primary write, load issue) so the youngest one decides the
            // final data and busy state.
            always_comb begin
                w_data_nxt = r_data;
                w_busy_nxt = r_busy;
                w_kill_nxt = r_kill;
                if (w_mem_hit) begin
                    if (r_kill) begin
                        // Stale return of an overtaken load: drop it.
                        w_kill_nxt = 1'b0;
                    end else begin
                        w_data_nxt = i_mem;
                        w_busy_nxt = 1'b0;
                    end
                end
                if (w_pw_hit) begin
                    // Overwriting a register with a load still pending
                    // means that load's return must be discarded.
                    w_kill_nxt = w_busy_nxt;
                    w_busy_nxt = 1'b0;
                    w_data_nxt = w_src;
                end
                if (w_ld_hit) begin
                    w_busy_nxt = 1'b1;
                    w_kill_nxt = 1'b0;
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_data <= RESET_VAL;
                    r_busy <= 1'b0;
                    r_kill <= 1'b0;
                end else begin
                    r_data <= w_data_nxt;
                    r_busy <= w_busy_nxt;
                    r_kill <= w_kill_nxt;
                end
            end

            assign w_data[gi] = r_data;
            assign w_busy[gi] = r_busy;
`ifdef REGBANK_SB_BYPASS_EN
            assign w_kill[gi] = r_kill;
`endif
        end
    endgenerate

    assign o_busy = w_busy;

`ifdef REGBANK_SB_BYPASS_EN
    logic w_a_pw;
    logic w_a_mem;
    logic w_a_ld;
    logic w_b_pw;
    logic w_b_mem;
    logic w_b_ld;

    assign w_a_pw  = w_pw_fire && (i_wsel == i_ra_sel);
    assign w_a_mem = i_mem_valid && (i_mem_dst == i_ra_sel) && !w_kill[i_ra_sel];
    assign w_a_ld  = w_ld_fire && (i_ld_dst == i_ra_sel);
    assign w_b_pw  = w_pw_fire && (i_wsel == i_rb_sel);
    assign w_b_mem = i_mem_valid && (i_mem_dst == i_rb_sel) && !w_kill[i_rb_sel];
    assign w_b_ld  = w_ld_fire && (i_ld_dst == i_rb_sel);

    // Primary write is younger than the MEM return, so it wins the forward.
    // A forwarded value is current, so busy only reflects a load issued
    // to the same index in this cycle.
    always_comb begin
        o_ra      = w_data[i_ra_sel];
        o_ra_busy = w_busy[i_ra_sel];
        if (w_a_pw) begin
            o_ra      = w_src;
            o_ra_busy = w_a_ld;
        end else if (w_a_mem) begin
            o_ra      = i_mem;
            o_ra_busy = w_a_ld;
        end
    end

    always_comb begin
        o_rb      = w_data[i_rb_sel];
        o_rb_busy = w_busy[i_rb_sel];
        if (w_b_pw) begin
            o_rb      = w_src;
            o_rb_busy = w_b_ld;
        end else if (w_b_mem) begin
            o_rb      = i_mem;
            o_rb_busy = w_b_ld;
        end
    end
`else
    assign o_ra      = w_data[i_ra_sel];
    assign o_rb      = w_data[i_rb_sel];
    assign o_ra_busy = w_busy[i_ra_sel];
    assign o_rb_busy = w_busy[i_rb_sel];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regbank_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_sb
// Description : Self-checking bench for regbank_sb (WIDTH=8, DEPTH=8).
//               Directed scenarios plus a randomized run against an
//               array-based reference model of the register bank.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regbank_sb;

    logic       clk;
    logic       rst;
    logic       e;
    logic       we;
    logic [2:0] wsel;
    logic [1:0] ms;
    logic [7:0] alu;
    logic [7:0] regv;
    logic [7:0] imm;
    logic       ld;
    logic [2:0] ld_dst;
    logic       mem_valid;
    logic [2:0] mem_dst;
    logic [7:0] mem;
    logic [2:0] ra_sel;
    logic [2:0] rb_sel;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       ra_busy;
    logic       rb_busy;
    logic [7:0] busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_data [8];
    logic [7:0] m_busy;
    logic [7:0] m_kill;

    regbank_sb #(.WIDTH(8), .DEPTH(8)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_e         (e),
        .i_we        (we),
        .i_wsel      (wsel),
        .i_ms        (ms),
        .i_alu       (alu),
        .i_reg       (regv),
        .i_imm       (imm),
        .i_ld_issue  (ld),
        .i_ld_dst    (ld_dst),
        .i_mem_valid (mem_valid),
        .i_mem_dst   (mem_dst),
        .i_mem       (mem),
        .i_ra_sel    (ra_sel),
        .i_rb_sel    (rb_sel),
        .o_ra        (ra),
        .o_rb        (rb),
        .o_ra_busy   (ra_busy),
        .o_rb_busy   (rb_busy),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] src_val();
        case (ms)
            2'd0:    return alu;
            2'd1:    return regv;
            2'd2:    return imm;
            default: return 8'h00;
        endcase
    endfunction

    // Expected read-port view for the current inputs and model state.
    function automatic void exp_read(input logic [2:0] sel, output logic [7:0] d, output logic b);
        d = m_data[sel];
        b = m_busy[sel];
`ifdef REGBANK_SB_BYPASS_EN
        if (we && e && wsel == sel) begin
            d = src_val();
            b = ld && e && ld_dst == sel;
        end else if (mem_valid && mem_dst == sel && !m_kill[sel]) begin
            d = mem;
            b = ld && e && ld_dst == sel;
        end
`endif
    endfunction

    task automatic idle();
        rst = 0; e = 1; we = 0; ld = 0; mem_valid = 0;
    endtask

    // Advance one clock; the model applies this cycle's events in age order.
    task automatic step();
        logic [7:0] nd [8];
        logic [7:0] nb;
        logic [7:0] nk;
        nd = m_data; nb = m_busy; nk = m_kill;
        if (rst) begin
            foreach (nd[i]) nd[i] = 8'h00;
            nb = '0;
            nk = '0;
        end else begin
            if (mem_valid) begin
                if (nk[mem_dst]) nk[mem_dst] = 1'b0;
                else begin
                    nd[mem_dst] = mem;
                    nb[mem_dst] = 1'b0;
                end
            end
            if (we && e) begin
                nk[wsel] = nb[wsel];
                nb[wsel] = 1'b0;
                nd[wsel] = src_val();
            end
            if (ld && e) begin
                nb[ld_dst] = 1'b1;
                nk[ld_dst] = 1'b0;
            end
        end
        @(posedge clk);
        m_data = nd; m_busy = nb; m_kill = nk;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; e = 1; we = 1; wsel = 3; ms = 0; alu = 8'h55;
        ld = 1; ld_dst = 2; mem_valid = 0; mem_dst = 0; mem = 0;
        regv = 8'h00; imm = 8'h00; ra_sel = 0; rb_sel = 0;
        step();
        idle();
        for (int r = 0; r < 8; r++) begin
            ra_sel = 3'(r); rb_sel = 3'(7 - r);
            #1;
            checks++;
            if (ra !== 8'h00) begin
                errors++;
                $display("FAIL reset_ra[%0d]: got %h expected 00", r, ra);
            end
            checks++;
            if (rb !== 8'h00) begin
                errors++;
                $display("FAIL reset_rb[%0d]: got %h expected 00", 7 - r, rb);
            end
        end
        checks++;
        if (busy !== 8'h00) begin
            errors++;
            $display("FAIL reset_busy: got %h expected 00", busy);
        end
    endtask

    task automatic test_source_select();
        idle(); we = 1; wsel = 2; ms = 2; imm = 8'h7B; alu = 8'h91; regv = 8'h92;
        step();
        idle(); ra_sel = 2; #1;
        checks++;
        if (ra !== 8'h7B) begin
            errors++;
            $display("FAIL src_imm: got %h expected 7b", ra);
        end
        we = 1; wsel = 4; ms = 1; regv = 8'h5A;
        step();
        idle(); rb_sel = 4; #1;
        checks++;
        if (rb !== 8'h5A) begin
            errors++;
            $display("FAIL src_reg: got %h expected 5a", rb);
        end
        we = 1; wsel = 2; ms = 3;
        step();
        idle(); ra_sel = 2; #1;
        checks++;
        if (ra !== 8'h00) begin
            errors++;
            $display("FAIL src_zero: got %h expected 00", ra);
        end
        // Disabled write and load issue must leave state untouched.
        e = 0; we = 1; wsel = 2; ms = 2; imm = 8'h7B; ld = 1; ld_dst = 2;
        step();
        idle(); ra_sel = 2; #1;
        checks++;
        if (ra !== 8'h00 || busy !== 8'h00) begin
            errors++;
            $display("FAIL enable_off: got ra=%h busy=%h expected ra=00 busy=00", ra, busy);
        end
    endtask

    task automatic test_load_path();
        idle(); ld = 1; ld_dst = 5;
        step();
        idle(); ra_sel = 5; #1;
        checks++;
        if (busy !== 8'h20 || ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy: got busy=%h ra_busy=%b expected 20/1", busy, ra_busy);
        end
        step();
        step();
        // Enable low must not block the return.
        e = 0; mem_valid = 1; mem_dst = 5; mem = 8'hC3;
        step();
        idle(); ra_sel = 5; #1;
        checks++;
        if (ra !== 8'hC3 || busy !== 8'h00) begin
            errors++;
            $display("FAIL load_return: got r5=%h busy=%h expected c3/00", ra, busy);
        end
    endtask

    task automatic test_waw_kill();
        idle(); ld = 1; ld_dst = 4;
        step();
        idle(); we = 1; wsel = 4; ms = 0; alu = 8'h11;
        step();
        idle(); ra_sel = 4; #1;
        checks++;
        if (busy[4] !== 1'b0 || ra !== 8'h11) begin
            errors++;
            $display("FAIL waw_write: got busy4=%b r4=%h expected 0/11", busy[4], ra);
        end
        mem_valid = 1; mem_dst = 4; mem = 8'hEE;
        step();
        idle(); ra_sel = 4; #1;
        checks++;
        if (ra !== 8'h11 || busy !== 8'h00) begin
            errors++;
            $display("FAIL waw_killed_return: got r4=%h busy=%h expected 11/00", ra, busy);
        end
        mem_valid = 1; mem_dst = 4; mem = 8'h22;
        step();
        idle(); ra_sel = 4; #1;
        checks++;
        if (ra !== 8'h22 || busy !== 8'h00) begin
            errors++;
            $display("FAIL waw_kill_cleared: got r4=%h busy=%h expected 22/00", ra, busy);
        end
    endtask

    task automatic test_collisions();
        idle(); ld = 1; ld_dst = 6;
        step();
        idle(); mem_valid = 1; mem_dst = 6; mem = 8'hAA; we = 1; wsel = 6; ms = 0; alu = 8'hBB;
        step();
        idle(); rb_sel = 6; #1;
        checks++;
        if (rb !== 8'hBB || rb_busy !== 1'b0) begin
            errors++;
            $display("FAIL coll_mem_we: got r6=%h busy=%b expected bb/0", rb, rb_busy);
        end
        mem_valid = 1; mem_dst = 6; mem = 8'hAA; ld = 1; ld_dst = 6;
        step();
        idle(); rb_sel = 6; #1;
        checks++;
        if (rb !== 8'hAA || rb_busy !== 1'b1 || busy !== 8'h40) begin
            errors++;
            $display("FAIL coll_mem_ld: got r6=%h busy=%h expected aa/40", rb, busy);
        end
        we = 1; wsel = 3; ms = 0; alu = 8'h77; ld = 1; ld_dst = 3;
        step();
        idle(); ra_sel = 3; #1;
        checks++;
        if (ra !== 8'h77 || ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL coll_we_ld: got r3=%h busy=%b expected 77/1", ra, ra_busy);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] exp_now;
        idle(); ra_sel = 1; #1;
        exp_now = m_data[1];
        we = 1; wsel = 1; ms = 0; alu = 8'h3C;
        #1;
`ifdef REGBANK_SB_BYPASS_EN
        exp_now = 8'h3C;
`endif
        checks++;
        if (ra !== exp_now) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h expected %h", ra, exp_now);
        end
        step();
        idle(); ra_sel = 1; #1;
        checks++;
        if (ra !== 8'h3C) begin
            errors++;
            $display("FAIL bypass_next_cycle: got %h expected 3c", ra);
        end
    endtask

    task automatic test_random();
        logic [7:0] ed;
        logic       eb;
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            e         = ($urandom_range(0, 7) != 0);
            we        = 1'($urandom);
            wsel      = 3'($urandom);
            ms        = 2'($urandom);
            alu       = 8'($urandom);
            regv      = 8'($urandom);
            imm       = 8'($urandom);
            ld        = ($urandom_range(0, 2) == 0);
            ld_dst    = 3'($urandom);
            mem_valid = ($urandom_range(0, 2) == 0);
            mem_dst   = 3'($urandom);
            mem       = 8'($urandom);
            ra_sel    = 3'($urandom);
            rb_sel    = 3'($urandom);
            #1;
            exp_read(ra_sel, ed, eb);
            checks++;
            if (ra !== ed || ra_busy !== eb) begin
                errors++;
                $display("FAIL rand_ra[%0d] sel=%0d: got %h/%b expected %h/%b", n, ra_sel, ra, ra_busy, ed, eb);
            end
            exp_read(rb_sel, ed, eb);
            checks++;
            if (rb !== ed || rb_busy !== eb) begin
                errors++;
                $display("FAIL rand_rb[%0d] sel=%0d: got %h/%b expected %h/%b", n, rb_sel, rb, rb_busy, ed, eb);
            end
            checks++;
            if (busy !== m_busy) begin
                errors++;
                $display("FAIL rand_busy[%0d]: got %h expected %h", n, busy, m_busy);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_source_select();
        test_load_path();
        test_waw_kill();
        test_collisions();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regbank_sb.md
# regbank_sb

Parametrised successor to the 8x8 register bank. Holds DEPTH registers of WIDTH bits. A single write port selects among ALU, REG and IMM sources. A second, independent memory write-back port completes loads. A per-register busy scoreboard marks registers with a load in flight, so the issue logic can stall on them. Two read ports are provided, and all storage is clocked on the rising edge of CLK.

## Interface
- WIDTH, 8: register width in bits.
- DEPTH, 8: number of registers; power of two, 2..64.
- AW, $clog2(DEPTH): register index width (derived; do not override).
- RESET_VAL, 0: value loaded into every register on reset.

- CLK  in  1  system clock; rising edge active.
- Reset  in  1  reset, synchronous, active-high.
- E  in  1  global enable; 0 suppresses WE and LD_ISSUE, but not MEM_VALID.
- WE  in  1  primary write request.
- WSEL  in  AW  primary write destination.
- MS  in  2  primary source: 0 ALU, 1 REG, 2 IMM, 3 zero.
- ALU, REG, IMM  in  WIDTH  primary write sources.
- LD_ISSUE  in  1  load issued; marks LD_DST busy.
- LD_DST  in  AW  load destination.
- MEM_VALID  in  1  load data returning this cycle.
- MEM_DST  in  AW  load write-back destination.
- MEM  in  WIDTH  load data.
- RA_SEL, RB_SEL  in  AW  read indices.
- RA, RB  out  WIDTH  read data (combinational from storage).
- RA_BUSY, RB_BUSY  out  1  busy bit of the selected register.
- BUSY  out  DEPTH  full scoreboard vector.

## Operation
- Per register i, the block holds data[i], busy[i] and kill[i]. All three are updated at the rising edge of CLK.
- Primary write fires when WE & E. It writes the MS-selected value to data[WSEL].
- Primary write to a busy register (WAW over a pending load):
  - clears busy[WSEL];
  - sets kill[WSEL], so the stale load return is discarded.
- Load issue fires when LD_ISSUE & E. It sets busy[LD_DST] and clears kill[LD_DST].
- MEM_VALID with kill[MEM_DST]=0:
  - writes MEM to data[MEM_DST];
  - clears busy[MEM_DST].
- MEM_VALID with kill[MEM_DST]=1:
  - leaves data unchanged;
  - clears kill[MEM_DST];
  - leaves busy unchanged.
- Priority for the same index in one cycle, from oldest to youngest:
  - MEM write-back, then primary write, then load issue;
  - the youngest data write wins;
  - the final busy state is that of the youngest event.
- MEM_VALID and primary write to the same index: primary data is stored, busy=0, kill=0.
- Primary write and LD_ISSUE to the same index: primary data is stored, busy=1, kill=0.
- MEM_VALID and LD_ISSUE to the same index: MEM data is stored, busy=1 (the new load is pending).
- Events on different indices proceed independently in the same cycle.
- Read ports: RA=data[RA_SEL] and RB=data[RB_SEL]. Reading a busy register returns stale data with RA_BUSY/RB_BUSY=1.
- MEM_VALID to a register with busy=0 and kill=0 (a spurious return) writes the data. Busy stays 0.

## Timing
- Reset (synchronous) sets every data[i]=RESET_VAL, busy=0 and kill=0. Outputs show this after the first CLK edge with Reset=1.
- Reset overrides all same-cycle writes. A load in flight across reset is forgotten. Its later MEM_VALID writes data (busy stays 0).
- Write latency is 1 cycle: data is visible on RA/RB in the cycle after the edge.
- Busy latency: RA_BUSY is asserted in the cycle after the LD_ISSUE edge and deasserts in the cycle after the MEM_VALID edge.
- There is no backpressure: MEM_VALID is always accepted.

## Configuration
- REGBANK_SB_BYPASS_EN defined:
  - A read index matching a firing primary write forwards the MS-selected data combinationally. RA_BUSY reads 0 unless LD_ISSUE hits the same index.
  - A read index matching an accepted (non-killed) MEM_VALID forwards MEM combinationally. RA_BUSY reads 0 unless LD_ISSUE hits the same index.
  - If both a primary write and a MEM write-back match, primary data is forwarded.
- REGBANK_SB_BYPASS_EN undefined:
  - reads return stored data only;
  - RA_BUSY/RB_BUSY reflect registered busy bits only.

## Test plan
- Reset value: Reset=1 for 1 cycle with WE=1, WSEL=3, ALU=8'h55 -> all registers read 8'h00 and BUSY=0.
- Source select:
  - WE=1, WSEL=2, MS=2, IMM=8'h7B -> next cycle RA_SEL=2 gives 8'h7B;
  - MS=3 -> writes 8'h00;
  - same write with E=0 -> no change.
- Load path: LD_ISSUE, LD_DST=5 -> BUSY=8'h20. Three cycles later MEM_VALID, MEM_DST=5, MEM=8'hC3 -> R5=8'hC3 and BUSY=0.
- WAW kill:
  - LD_ISSUE to 4, then WE to 4 with ALU=8'h11 -> BUSY[4]=0;
  - later MEM_VALID to 4 with MEM=8'hEE -> R4 stays 8'h11 and kill[4] clears.
  - A second MEM_VALID to 4 with MEM=8'h22 -> R4=8'h22.
- Same-cycle collisions on index 6:
  - MEM_VALID with MEM=8'hAA and WE with ALU=8'hBB -> R6=8'hBB, busy 0;
  - MEM_VALID and LD_ISSUE -> R6=8'hAA, busy 1.
- Bypass (macro on): WE, WSEL=1, ALU=8'h3C, RA_SEL=1 -> RA=8'h3C in the same cycle. With the macro off, RA shows the old value until the next cycle.
